// File: rtl/bcd_seg_pkg.sv
// Shared constants for the three-digit multiplexed 7-segment scanner:
// segment codes, digit slot indices and one-hot common selects.
package bcd_seg_pkg;

  localparam int NUM_DIGITS = 3;

  localparam logic [1:0] IDX_ONES = 2'd0;
  localparam logic [1:0] IDX_TENS = 2'd1;
  localparam logic [1:0] IDX_HUND = 2'd2;
  localparam logic [1:0] IDX_LAST = 2'(NUM_DIGITS - 1);

  localparam logic [2:0] SEL_ONES = 3'b001;
  localparam logic [2:0] SEL_TENS = 3'b010;
  localparam logic [2:0] SEL_HUND = 3'b100;

  // Logical (active-high) patterns, bit6 = g ... bit0 = a.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational nibble to logical 7-segment decode; non-BCD nibbles show a dash.
module bcd_to_seg
  import bcd_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Digit lookup, A-F fall through to the dash pattern.
  always_comb begin
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// Three-digit multiplexed 7-segment scanner with frame shadow and sticky overflow dp.
// Optional build macro BCD_SEG_BLANK_EN enables leading-zero blanking.
module bcd_seg_scan
  import bcd_seg_pkg::*;
#(
  parameter int SCAN_DIV    = 50000,
  parameter int SEG_ACT_LOW = 1,
  parameter int DIG_ACT_LOW = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] bcd,
  input  logic        ovf_in,
  input  logic        ovf_clr,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [2:0]  dig_sel
);

  localparam int             PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(SCAN_DIV - 1);
  // Inactive pin levels double as XOR masks that map logical levels to pins.
  localparam logic [6:0]     SEG_OFF  = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic           DP_OFF   = (SEG_ACT_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [2:0]     DIG_OFF  = (DIG_ACT_LOW != 0) ? 3'b111 : 3'b000;

  logic [PW-1:0] pre_q, pre_d;
  logic [1:0]    idx_q, idx_d;
  logic [11:0]   shadow_q, shadow_d;
  logic          ovf_flag_q, ovf_flag_d;
  logic          live_q, live_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [2:0]    dig_sel_q, dig_sel_d;

  logic [3:0]    nibble;
  logic [2:0]    sel_log;
  logic [6:0]    dec_seg;
  logic [6:0]    seg_log;
  logic          dp_log;

  // Prescaler, slot index and frame shadow; the shadow only reloads on the 2->0 wrap.
  always_comb begin
    pre_d    = pre_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    if (pre_q == PRE_LAST) begin
      pre_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d    = IDX_ONES;
        shadow_d = bcd;
      end else begin
        idx_d = idx_q + 2'd1;
      end
    end else begin
      pre_d = pre_q + PW'(1);
    end

    if (ovf_in) begin
      ovf_flag_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_flag_d = 1'b0;
    end else begin
      ovf_flag_d = ovf_flag_q;
    end

    live_d = 1'b1;
  end

  // Slot multiplexer; an out-of-range index falls back to the ones slot.
  always_comb begin
    case (idx_q)
      IDX_TENS: begin nibble = shadow_q[7:4];  sel_log = SEL_TENS; end
      IDX_HUND: begin nibble = shadow_q[11:8]; sel_log = SEL_HUND; end
      default:  begin nibble = shadow_q[3:0];  sel_log = SEL_ONES; end
    endcase
  end

  bcd_to_seg u_dec (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  // Leading-zero blanking; ones is never blanked.
  always_comb begin
`ifdef BCD_SEG_BLANK_EN
    if ((idx_q == IDX_HUND) && (shadow_q[11:8] == 4'h0)) begin
      seg_log = SEG_BLANK;
    end else if ((idx_q == IDX_TENS) && (shadow_q[11:4] == 8'h00)) begin
      seg_log = SEG_BLANK;
    end else begin
      seg_log = dec_seg;
    end
`else
    seg_log = dec_seg;
`endif
    dp_log = (idx_q == IDX_HUND) && ovf_flag_q;
  end

  // Pin levels; live_q holds the outputs inactive for one cycle after reset release.
  always_comb begin
    if (live_q) begin
      seg_d     = seg_log ^ SEG_OFF;
      dp_d      = dp_log ^ DP_OFF;
      dig_sel_d = sel_log ^ DIG_OFF;
    end else begin
      seg_d     = SEG_OFF;
      dp_d      = DP_OFF;
      dig_sel_d = DIG_OFF;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q      <= '0;
      idx_q      <= IDX_ONES;
      shadow_q   <= 12'h000;
      ovf_flag_q <= 1'b0;
      live_q     <= 1'b0;
      seg_q      <= SEG_OFF;
      dp_q       <= DP_OFF;
      dig_sel_q  <= DIG_OFF;
    end else begin
      pre_q      <= pre_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      ovf_flag_q <= ovf_flag_d;
      live_q     <= live_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      dig_sel_q  <= dig_sel_d;
    end
  end

  assign seg     = seg_q;
  assign dp      = dp_q;
  assign dig_sel = dig_sel_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Scoreboard bench for bcd_seg_scan (SCAN_DIV=4, active-low pins); honours BCD_SEG_BLANK_EN.
module tb_bcd_seg_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] bcd;
  logic        ovf_in;
  logic        ovf_clr;
  logic [6:0]  seg;
  logic        dp;
  logic [2:0]  dig_sel;

  always #5 clk = ~clk;

  bcd_seg_scan #(
    .SCAN_DIV    (4),
    .SEG_ACT_LOW (1),
    .DIG_ACT_LOW (1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bcd     (bcd),
    .ovf_in  (ovf_in),
    .ovf_clr (ovf_clr),
    .seg     (seg),
    .dp      (dp),
    .dig_sel (dig_sel)
  );

  localparam logic [10:0] INACT = {7'h7F, 1'b1, 3'b111};

  logic [10:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int timeouts = 0;
  bit done     = 1'b0;

  function automatic logic [6:0] code_of(input logic [3:0] n);
    case (n)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  function automatic logic [6:0] digit_code(input logic [11:0] sh, input int slot);
    logic [6:0] c;
    case (slot)
      1:       c = code_of(sh[7:4]);
      2:       c = code_of(sh[11:8]);
      default: c = code_of(sh[3:0]);
    endcase
`ifdef BCD_SEG_BLANK_EN
    if (slot == 2 && sh[11:8] == 4'h0) c = 7'h00;
    if (slot == 1 && sh[11:4] == 8'h00) c = 7'h00;
`endif
    return c;
  endfunction

  task automatic push_slot(input logic [11:0] sh, input int slot, input logic dpl);
    logic [2:0] sel;
    sel = 3'(1 << slot);
    exp_q.push_back({~digit_code(sh, slot), ~dpl, ~sel});
  endtask

  // Remaining slots of the current frame plus the ones slot of the next frame.
  task automatic step(input logic [11:0] cur, input logic dph, input logic [11:0] nxt);
    push_slot(cur, 1, 1'b0);
    push_slot(cur, 2, dph);
    push_slot(nxt, 0, 1'b0);
  endtask

  task automatic wait_dig(input logic [2:0] v);
    logic [2:0] last;
    last = dig_sel;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dig_sel == v && last != v) return;
      last = dig_sel;
    end
    timeouts++;
  endtask

  task automatic pulse(input logic i, input logic c);
    ovf_in  = i;
    ovf_clr = c;
    @(negedge clk);
    ovf_in  = 1'b0;
    ovf_clr = 1'b0;
  endtask

  // Stimulus
  initial begin
    rst_n   = 1'b0;
    bcd     = 12'h123;
    ovf_in  = 1'b0;
    ovf_clr = 1'b0;
    exp_q.push_back(INACT);
    push_slot(12'h000, 0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_dig(3'b110);                       // frame 0 (shadow 000)
    step(12'h000, 1'b0, 12'h123);
    wait_dig(3'b110);                       // frame 1 (123)
    bcd = 12'h456;                          // mid-frame change
    step(12'h123, 1'b0, 12'h456);
    wait_dig(3'b110);                       // frame 2 (456)
    step(12'h456, 1'b1, 12'h456);
    pulse(1'b1, 1'b0);
    wait_dig(3'b110);                       // frame 3
    bcd = 12'h0A5;
    step(12'h456, 1'b1, 12'h0A5);
    pulse(1'b1, 1'b1);
    wait_dig(3'b110);                       // frame 4 (0A5)
    bcd = 12'h007;
    step(12'h0A5, 1'b0, 12'h007);
    pulse(1'b0, 1'b1);
    wait_dig(3'b110);                       // frame 5 (007)
    push_slot(12'h007, 1, 1'b0);
    push_slot(12'h007, 2, 1'b1);
    pulse(1'b1, 1'b0);
    wait_dig(3'b011);                       // hundreds slot: reset mid-scan
    exp_q.push_back(INACT);
    push_slot(12'h000, 0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_dig(3'b110);
    step(12'h000, 1'b0, 12'h007);
    wait_dig(3'b110);
    step(12'h007, 1'b0, 12'h007);
    wait_dig(3'b110);
    repeat (2) @(negedge clk);
    done = 1'b1;
  end

  // Monitor: every change of the output vector is a presented output.
  initial begin
    logic [10:0] prev, cur, e;
    bit first;
    bit after_inact;
    int run;
    int want;
    first = 1'b1;
    after_inact = 1'b1;
    run = 0;
    prev = INACT;
    while (!done) begin
      @(negedge clk);
      cur = {seg, dp, dig_sel};
      if (first || cur !== prev) begin
        if (!first && cur[2:0] !== prev[2:0]) begin
          if (prev[2:0] != 3'b111 && cur[2:0] != 3'b111) begin
            want = after_inact ? 3 : 4;
            checks++;
            if (run != want) begin
              failures++;
              $display("FAIL slot_len: got %0d cycles expected %0d (dig_sel %b)", run, want, prev[2:0]);
            end
            after_inact = 1'b0;
          end else if (cur[2:0] == 3'b111) begin
            after_inact = 1'b1;
          end else begin
            after_inact = after_inact;
          end
          run = 0;
        end
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output: got seg=%h dp=%b dig_sel=%b expected none", cur[10:4], cur[3], cur[2:0]);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            failures++;
            $display("FAIL output: got seg=%h dp=%b dig_sel=%b expected seg=%h dp=%b dig_sel=%b",
                     cur[10:4], cur[3], cur[2:0], e[10:4], e[3], e[2:0]);
          end
        end
        prev = cur;
        first = 1'b0;
      end
      run++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover: got %0d pending expected 0", exp_q.size());
    end
    checks++;
    if (timeouts != 0) begin
      failures++;
      $display("FAIL wait_timeout: got %0d timeouts expected 0", timeouts);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit
  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before 100000ns");
    $fatal(1, "watchdog expired");
  end

endmodule
